// File: rtl/nonblocking_swap_pipe.sv
// Two-lane DEPTH-stage register pipeline with an entry lane transform, stall, flush and
// occupancy count. Every output comes straight from a register.
module nonblocking_swap_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [1:0] ModePass = 2'b00;
  localparam logic [1:0] ModeSwap = 2'b01;
  localparam logic [1:0] ModeDupA = 2'b10;
  localparam logic [1:0] ModeXor  = 2'b11;

  logic             r_v [DEPTH];
  logic [WIDTH-1:0] r_a [DEPTH];
  logic [WIDTH-1:0] r_b [DEPTH];
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;

  // Bubbles always carry zero data.
  always_comb begin
    w_a_in = '0;
    w_b_in = '0;
    if (valid_i) begin
      unique case (mode_i)
        ModePass: begin w_a_in = a_i;       w_b_in = b_i; end
        ModeSwap: begin w_a_in = b_i;       w_b_in = a_i; end
        ModeDupA: begin w_a_in = a_i;       w_b_in = a_i; end
        ModeXor:  begin w_a_in = a_i ^ b_i; w_b_in = b_i; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_count <= '0;
    end else if (en_i) begin
      r_v[0] <= valid_i;
      r_a[0] <= w_a_in;
      r_b[0] <= w_b_in;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      // Enter and leave in the same edge leave the count unchanged.
      r_count <= r_count + CW'(valid_i) - CW'(r_v[DEPTH-1]);
    end
  end

  assign valid_o = r_v[DEPTH-1];
  assign a_o     = r_a[DEPTH-1];
  assign b_o     = r_b[DEPTH-1];
  assign count_o = r_count;

endmodule

// File: doc/nonblocking_swap_pipe.md
# nonblocking_swap_pipe

Parametrised successor to the two-lane nonblocking swap register. It carries two WIDTH-bit lanes (a, b) through a DEPTH-stage register pipeline. A per-beat lane transform (pass, swap, duplicate, xor) is applied at entry. The block adds valid tracking, stall, flush and an occupancy counter. It sits between a producer and consumer in the lab datapaths and is the standard exerciser for nonblocking-assignment pipeline semantics.

## Interface
- WIDTH, 8, bit width of each lane; legal range is 1 or more.
- DEPTH, 4, number of pipeline stages, which equals the latency in advancing cycles; legal range is 1 or more.
- CW, $clog2(DEPTH+1), derived (localparam), width of count_o.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en_i  input  1  advance enable; 0 stalls the entire pipeline.
- flush_i  input  1  synchronous clear of pipeline contents; reset is not required.
- valid_i  input  1  input beat is valid.
- mode_i  input  2  lane transform for the entering beat.
- a_i  input  WIDTH  lane A input.
- b_i  input  WIDTH  lane B input.
- valid_o  output  1  last stage holds a valid beat.
- a_o  output  WIDTH  lane A of the last stage.
- b_o  output  WIDTH  lane B of the last stage.
- count_o  output  CW  number of stages holding valid beats, in the range 0..DEPTH.

## Operation
- State: DEPTH stages, each holding {v, a, b}. Stage 0 is the entry stage; stage DEPTH-1 drives the outputs directly.
- Entry transform, applied only when valid_i=1 (a' = value loaded into lane A, b' = value loaded into lane B):
  - 00 PASS: a'=a_i, b'=b_i.
  - 01 SWAP: a'=b_i, b'=a_i.
  - 10 DUPA: a'=a_i, b'=a_i.
  - 11 XOR: a'=a_i^b_i, b'=b_i.
- Invalid entry (valid_i=0): stage 0 loads v=0, a=0, b=0. Data inside bubbles is always zero.
- Advance (en_i=1, flush_i=0, rst=0):
  - Stage k loads stage k-1 for k = 1..DEPTH-1.
  - Stage 0 loads the transformed input.
  - All stages update simultaneously: a true shift register, with no stage seeing a same-cycle updated neighbour.
- Stall (en_i=0): all stages and count_o hold. valid_i, mode_i, a_i and b_i are ignored.
- Delivery: a beat is consumed on an edge where en_i=1 and valid_o=1. A stalled valid_o stays high and is not a repeat delivery.
- Counter: on advance, count_o_next = count_o + valid_i - valid_o, using the pre-edge values. It must never exceed DEPTH or go below 0; this is an assertion in the bench.
- Flush/reset priority: rst > flush_i > en_i.
  - rst or flush_i: all v, a, b and count_o go to 0 on the next edge, regardless of en_i.
  - An input presented in the same cycle as flush_i is dropped.
- DEPTH=1: stage 0 is the output stage, and count_o equals valid_o.

## Timing
- Reset values: valid_o=0, a_o=0, b_o=0, count_o=0. The first edge with rst=1 establishes these.
- Latency: a beat accepted at edge t appears on the outputs after DEPTH advancing edges. With en_i continuously high, that is DEPTH cycles.
- Stall cycles add exactly their count to latency; beat order and spacing are preserved.
- Throughput: one beat per advancing cycle, with no back-pressure output; the producer is gated by en_i.
- Outputs are pure registers, with no combinational path from any input to any output.
- Reset or flush mid-stream: in-flight beats are discarded and never appear on the outputs. Accepting input resumes on the first edge with rst=0 and flush_i=0.
- Simultaneous enter-and-leave at full occupancy (count_o=DEPTH, valid_i=1, en_i=1): count_o stays at DEPTH.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset: hold rst=1 for 2 cycles with random inputs -> valid_o=0, a_o=b_o=0x00, count_o=0. After release, outputs stay 0 until the first valid beat reaches the output stage.
- Per-mode latency: a_i=0xA5, b_i=0x3C, one valid beat each in modes 00, 01, 10 and 11 on consecutive cycles, en_i=1 -> valid_o is high on cycles 4..7 with (a_o,b_o) = (A5,3C), (3C,A5), (A5,A5), (99,3C).
- Stall: stream 0x01..0x06 on lane A in PASS mode, drop en_i for 3 cycles mid-stream -> outputs freeze, no values lost or duplicated, final sequence is 01..06, count_o is constant during the stall.
- Occupancy: 4 valid beats then bubbles -> count_o goes 1, 2, 3, 4, then holds 4 while the stream is continuous, then decrements to 0 as the tail drains. Steady-state full streaming keeps count_o=4.
- Flush: fill with 3 beats and assert flush_i together with valid_i=1 and en_i=0 -> on the next edge valid_o=0, count_o=0, data=0. None of the 3 beats or the flush-cycle input ever appears.
- Reset mid-stream: continuous random traffic with rst pulsed for 1 cycle -> all state is 0 after the edge. A scoreboard comparison against a reference queue, cleared at reset, passes with zero mismatches over 1000 beats.
